// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding select, load-use detection, long-op scoreboard,
// branch-over-stall priority, saturating stall counter and stall watchdog
// for the in-order 5-stage RV64 pipeline.
module hazard_ctrl #(
  parameter int REG_W     = 5,
  parameter int CNT_W     = 32,
  parameter int MAX_STALL = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [REG_W-1:0]        Rs1_D,
  input  logic [REG_W-1:0]        Rs2_D,
  input  logic                    Use_Rs1_D,
  input  logic                    Use_Rs2_D,
  input  logic [REG_W-1:0]        Rd_D,
  input  logic                    RegWrite_D,
  input  logic                    Long_D,
  input  logic [REG_W-1:0]        Rs1_E,
  input  logic [REG_W-1:0]        Rs2_E,
  input  logic [REG_W-1:0]        Rd_E,
  input  logic [1:0]              ResultSrc_E,
  input  logic                    PCSrc_E,
  input  logic                    LongIssue_E,
  input  logic                    LongBusy,
  input  logic                    LongDone,
  input  logic [REG_W-1:0]        LongRd,
  input  logic [REG_W-1:0]        Rd_M,
  input  logic                    RegWrite_M,
  input  logic [REG_W-1:0]        Rd_W,
  input  logic                    RegWrite_W,
  output logic [1:0]              ForwardA_E,
  output logic [1:0]              ForwardB_E,
  output logic                    Stall_F,
  output logic                    Stall_D,
  output logic                    Flush_D,
  output logic                    Flush_E,
  output logic [(1<<REG_W)-1:0]   Pending,
  output logic [CNT_W-1:0]        StallCount,
  output logic                    StallTimeout
);

  localparam int NREG = 1 << REG_W;
  localparam int WD_W = $clog2(MAX_STALL + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(MAX_STALL);
  localparam logic [WD_W-1:0] WD_TRIP = WD_W'(MAX_STALL - 1);

  logic [NREG-1:0]  r_pend;
  logic [NREG-1:0]  w_pend_next;
  logic [NREG-1:0]  w_pend_eff;
  logic [NREG-1:0]  w_done_vec;
  logic [NREG-1:0]  w_issue_vec;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [WD_W-1:0]  r_consec;
  logic             r_timeout;
  logic             w_lw_stall;
  logic             w_sb_stall;
  logic             w_stall;

  // M has priority over W; x0 is hardwired and never forwarded
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs,
                                         input logic [REG_W-1:0] rd_m,
                                         input logic             we_m,
                                         input logic [REG_W-1:0] rd_w,
                                         input logic             we_w);
    if (rs != '0 && rs == rd_m && we_m)      return 2'b10;
    else if (rs != '0 && rs == rd_w && we_w) return 2'b01;
    else                                     return 2'b00;
  endfunction

  assign ForwardA_E = fwd_sel(Rs1_E, Rd_M, RegWrite_M, Rd_W, RegWrite_W);
  assign ForwardB_E = fwd_sel(Rs2_E, Rd_M, RegWrite_M, Rd_W, RegWrite_W);

  // one-hot decode of completing and issuing destinations; x0 never tracked
  always_comb begin
    w_done_vec  = '0;
    w_issue_vec = '0;
    if (LongDone)    w_done_vec[LongRd] = 1'b1;
    if (LongIssue_E) w_issue_vec[Rd_E]  = 1'b1;
    w_issue_vec[0] = 1'b0;
  end

  // write-first register file: a completing result is already readable
  assign w_pend_eff  = r_pend & ~w_done_vec;
  // issue beats completion on the same register
  assign w_pend_next = w_pend_eff | w_issue_vec;

  assign w_lw_stall = (ResultSrc_E == 2'b01) && (Rd_E != '0) &&
                      ((Use_Rs1_D && Rs1_D == Rd_E) || (Use_Rs2_D && Rs2_D == Rd_E));

  assign w_sb_stall = (Use_Rs1_D && w_pend_eff[Rs1_D]) ||
                      (Use_Rs2_D && w_pend_eff[Rs2_D]) ||
                      (RegWrite_D && Rd_D != '0 && w_pend_eff[Rd_D]) ||
                      (Long_D && (LongBusy || LongIssue_E));

  // a taken branch kills Decode, so never stall a wrong-path instruction
  assign w_stall = (w_lw_stall || w_sb_stall) && !PCSrc_E;

  assign Stall_F = w_stall;
  assign Stall_D = w_stall;
  assign Flush_D = PCSrc_E;
  assign Flush_E = w_stall || PCSrc_E;

  // scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= w_pend_next;
  end

  // saturating total stall-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_stall_cnt <= '0;
    else if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  // watchdog: consecutive-stall run length and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_consec  <= '0;
      r_timeout <= 1'b0;
    end else if (w_stall) begin
      if (r_consec != WD_MAX)  r_consec  <= r_consec + 1'b1;
      if (r_consec >= WD_TRIP) r_timeout <= 1'b1;
    end else begin
      r_consec <= '0;
    end
  end

  assign Pending      = r_pend;
  assign StallCount   = r_stall_cnt;
  assign StallTimeout = r_timeout;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table of combinational vectors plus
// directed multi-cycle sequences for scoreboard, counters, watchdog, reset.
module tb_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam int MAXS  = 4;

  logic clk, rst_n;
  logic [4:0] Rs1_D, Rs2_D, Rd_D, Rs1_E, Rs2_E, Rd_E, LongRd, Rd_M, Rd_W;
  logic Use_Rs1_D, Use_Rs2_D, RegWrite_D, Long_D, PCSrc_E, LongIssue_E;
  logic LongBusy, LongDone, RegWrite_M, RegWrite_W;
  logic [1:0] ResultSrc_E, ForwardA_E, ForwardB_E;
  logic Stall_F, Stall_D, Flush_D, Flush_E, StallTimeout;
  logic [31:0] Pending;
  logic [CNT_W-1:0] StallCount;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MAX_STALL(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Use_Rs1_D(Use_Rs1_D), .Use_Rs2_D(Use_Rs2_D),
    .Rd_D(Rd_D), .RegWrite_D(RegWrite_D), .Long_D(Long_D),
    .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E), .ResultSrc_E(ResultSrc_E),
    .PCSrc_E(PCSrc_E), .LongIssue_E(LongIssue_E), .LongBusy(LongBusy),
    .LongDone(LongDone), .LongRd(LongRd),
    .Rd_M(Rd_M), .RegWrite_M(RegWrite_M), .Rd_W(Rd_W), .RegWrite_W(RegWrite_W),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D), .Flush_E(Flush_E),
    .Pending(Pending), .StallCount(StallCount), .StallTimeout(StallTimeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1_d, rs2_d; logic u1, u2; logic [4:0] rd_d; logic rw_d, lg_d;
    logic [4:0] rs1_e, rs2_e, rd_e; logic [1:0] rsrc; logic pcs, busy;
    logic [4:0] rd_m; logic rw_m; logic [4:0] rd_w; logic rw_w;
    logic [1:0] fa, fb; logic st, fd, fe;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic st, input logic fd, input logic fe);
    check({tag, " Stall_F"}, 64'(Stall_F), 64'(st));
    check({tag, " Stall_D"}, 64'(Stall_D), 64'(st));
    check({tag, " Flush_D"}, 64'(Flush_D), 64'(fd));
    check({tag, " Flush_E"}, 64'(Flush_E), 64'(fe));
  endtask

  task automatic clear_inputs();
    Rs1_D = 0; Rs2_D = 0; Use_Rs1_D = 0; Use_Rs2_D = 0; Rd_D = 0; RegWrite_D = 0;
    Long_D = 0; Rs1_E = 0; Rs2_E = 0; Rd_E = 0; ResultSrc_E = 0; PCSrc_E = 0;
    LongIssue_E = 0; LongBusy = 0; LongDone = 0; LongRd = 0;
    Rd_M = 0; RegWrite_M = 0; Rd_W = 0; RegWrite_W = 0;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    //             rs1d rs2d u1 u2 rdd rwd lgd rs1e rs2e rde rsrc pcs busy rdm rwm rdw rww  fa fb st fd fe
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 5, 1, 5, 1,  2, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 5, 1,  1, 0, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1,  0, 0, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0, 0, 0, 6, 0, 6, 1,  0, 1, 0, 0, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 3, 3, 0, 0, 0, 0, 3, 1, 0, 0,  2, 2, 0, 0, 0};
    vecs[6]  = '{0, 7, 0, 1, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1};
    vecs[7]  = '{0, 7, 0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    vecs[8]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    vecs[9]  = '{0, 7, 0, 1, 0, 0, 0, 0, 0, 7, 2, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    vecs[10] = '{7, 0, 1, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1};
    vecs[11] = '{0, 7, 0, 1, 0, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1};
    vecs[12] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 0, 1, 0, 1};
    vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1};

    clear_inputs();
    rst_n = 1'b0;
    #12;
    // reset state
    check("rst Pending", 64'(Pending), 64'd0);
    check("rst StallCount", 64'(StallCount), 64'd0);
    check("rst StallTimeout", 64'(StallTimeout), 64'd0);
    chk_ctl("rst ctl", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // combinational vector table
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      Rs1_D = vecs[i].rs1_d; Rs2_D = vecs[i].rs2_d; Use_Rs1_D = vecs[i].u1; Use_Rs2_D = vecs[i].u2;
      Rd_D = vecs[i].rd_d; RegWrite_D = vecs[i].rw_d; Long_D = vecs[i].lg_d;
      Rs1_E = vecs[i].rs1_e; Rs2_E = vecs[i].rs2_e; Rd_E = vecs[i].rd_e;
      ResultSrc_E = vecs[i].rsrc; PCSrc_E = vecs[i].pcs; LongBusy = vecs[i].busy;
      Rd_M = vecs[i].rd_m; RegWrite_M = vecs[i].rw_m; Rd_W = vecs[i].rd_w; RegWrite_W = vecs[i].rw_w;
      #1;
      check($sformatf("vec%0d ForwardA_E", i), 64'(ForwardA_E), 64'(vecs[i].fa));
      check($sformatf("vec%0d ForwardB_E", i), 64'(ForwardB_E), 64'(vecs[i].fb));
      chk_ctl($sformatf("vec%0d", i), vecs[i].st, vecs[i].fd, vecs[i].fe);
    end

    // watchdog: a broken run must restart the consecutive count
    reset_pulse();
    Long_D = 1; LongBusy = 1;
    repeat (3) @(negedge clk);
    #1 check("wd run1 StallTimeout", 64'(StallTimeout), 64'd0);
    LongBusy = 0;
    #1 chk_ctl("wd gap", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    LongBusy = 1;
    repeat (3) @(negedge clk);
    #1 check("wd run2 3cyc StallTimeout", 64'(StallTimeout), 64'd0);
    @(negedge clk);
    #1 check("wd run2 4cyc StallTimeout", 64'(StallTimeout), 64'd1);
    LongBusy = 0; Long_D = 0;
    repeat (2) @(negedge clk);
    #1 check("wd sticky StallTimeout", 64'(StallTimeout), 64'd1);
    check("wd StallCount", 64'(StallCount), 64'd7);

    // scoreboard RAW on x9
    reset_pulse();
    LongIssue_E = 1; Rd_E = 9;
    #1 chk_ctl("raw issue", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      LongIssue_E = 0; Rd_E = 0; Rs1_D = 9; Use_Rs1_D = 1;
      #1 chk_ctl($sformatf("raw wait%0d", i), 1'b1, 1'b0, 1'b1);
      check($sformatf("raw wait%0d Pending", i), 64'(Pending), 64'h200);
    end
    @(negedge clk);
    LongDone = 1; LongRd = 9;
    #1 chk_ctl("raw done", 1'b0, 1'b0, 1'b0);
    check("raw done Pending", 64'(Pending), 64'h200);
    @(negedge clk);
    LongDone = 0; LongRd = 0;
    #1 check("raw after Pending", 64'(Pending), 64'd0);
    chk_ctl("raw after", 1'b0, 1'b0, 1'b0);
    check("raw StallCount", 64'(StallCount), 64'd7);

    // structural stall and counter saturation (7 + 10 > 15)
    Use_Rs1_D = 0; Rs1_D = 0; Long_D = 1; LongBusy = 1;
    for (int i = 0; i < 10; i++) begin
      #1 chk_ctl($sformatf("busy%0d", i), 1'b1, 1'b0, 1'b1);
      @(negedge clk);
    end
    LongBusy = 0;
    #1 chk_ctl("busy released", 1'b0, 1'b0, 1'b0);
    check("sat StallCount", 64'(StallCount), 64'd15);
    LongIssue_E = 1; Rd_E = 0;
    #1 chk_ctl("issue struct", 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    LongIssue_E = 0; Long_D = 0;
    #1 check("x0 untracked Pending", 64'(Pending), 64'd0);
    check("sat hold StallCount", 64'(StallCount), 64'd15);

    // WAW, same-cycle set/clear, completion of a non-pending register
    @(negedge clk);
    LongIssue_E = 1; Rd_E = 3;
    @(negedge clk);
    LongIssue_E = 0; Rd_E = 0;
    #1 check("waw Pending", 64'(Pending), 64'h8);
    Rs1_D = 3; Use_Rs1_D = 0;
    #1 chk_ctl("unused src", 1'b0, 1'b0, 1'b0);
    RegWrite_D = 1; Rd_D = 3;
    #1 chk_ctl("waw", 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    LongDone = 1; LongRd = 3; LongIssue_E = 1; Rd_E = 3;
    #1 chk_ctl("waw done bypass", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    LongIssue_E = 0; Rd_E = 0; RegWrite_D = 0; Rd_D = 0; LongRd = 5;
    #1 check("set wins Pending", 64'(Pending), 64'h8);
    @(negedge clk);
    LongRd = 3;
    #1 check("noop done Pending", 64'(Pending), 64'h8);
    @(negedge clk);
    LongDone = 0; LongRd = 0;
    #1 check("clear Pending", 64'(Pending), 64'd0);

    // asynchronous reset mid-pending
    reset_pulse();
    LongIssue_E = 1; Rd_E = 12;
    @(negedge clk);
    LongIssue_E = 0; Rd_E = 0; Long_D = 1; LongBusy = 1;
    repeat (4) @(negedge clk);
    #1 check("pre-rst Pending", 64'(Pending), 64'h1000);
    check("pre-rst StallTimeout", 64'(StallTimeout), 64'd1);
    check("pre-rst StallCount", 64'(StallCount), 64'd4);
    #1 rst_n = 1'b0;
    #1 check("async rst Pending", 64'(Pending), 64'd0);
    check("async rst StallCount", 64'(StallCount), 64'd0);
    check("async rst StallTimeout", 64'(StallTimeout), 64'd0);
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    LongDone = 1; LongRd = 12;
    @(negedge clk);
    LongDone = 0; LongRd = 0;
    #1 check("post-rst Pending", 64'(Pending), 64'd0);
    check("post-rst StallCount", 64'(StallCount), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
